pc_fetch: RTL

Program-counter-driven instruction fetch unit: the reading end of the program memory. It holds the program counter, issues synchronous reads to the instruction memory and presents each fetched word with its address on a valid/ready handshake to the downstream decoder. It sits between the memory array and the decode/execute stage, and accepts redirects (jump/branch loads) from the core.

---
 rtl/pc_fetch_pkg.sv | 17 +
 rtl/pc_fetch_pc_reg.sv | 37 +++
 rtl/pc_fetch.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths and FSM state encoding.
package pc_fetch_pkg;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_PC_STEP  = 1;
  localparam int DEF_RESET_PC = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    CAPTURE = 3'd2,
    HOLD    = 3'd3,
    STOP    = 3'd4
  } state_t;

endpackage

// File: rtl/pc_fetch_pc_reg.sv
// Program counter register: sync reset to RESET_PC, redirect load, and increment by PC_STEP.
// Also reports the carry out of the increment so the fetch unit can detect overflow.
module pc_reg
  import pc_fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int PC_STEP  = DEF_PC_STEP,
  parameter int RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic              carry
);

  logic [ADDR_W-1:0] value_reg;
  logic [ADDR_W:0]   sum;

  // One extra bit so the carry out of the ADDR_W-bit increment is visible.
  assign sum   = {1'b0, value_reg} + (ADDR_W+1)'(PC_STEP);
  assign pc    = value_reg;
  assign carry = sum[ADDR_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      value_reg <= ADDR_W'(RESET_PC);
    end else if (load) begin
      value_reg <= load_addr;
    end else if (inc) begin
      value_reg <= sum[ADDR_W-1:0];
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch unit: PC-driven synchronous memory reads delivered on a valid/ready handshake.
// Optional PC overflow stop/err is enabled by defining PC_FETCH_BOUND_EN.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int PC_STEP  = DEF_PC_STEP,
  parameter int RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              err
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc;
  logic              carry;
  logic              inc;
  logic              instr_valid_reg;
  logic [DATA_W-1:0] instr_reg;
  logic [ADDR_W-1:0] instr_pc_reg;

  // A redirect in CAPTURE overrides the increment; the word being captured is dropped.
  assign inc = (state_reg == CAPTURE) && !load;

  pc_reg #(
    .ADDR_W  (ADDR_W),
    .PC_STEP (PC_STEP),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_addr(load_addr),
    .inc      (inc),
    .pc       (pc),
    .carry    (carry)
  );

`ifdef PC_FETCH_BOUND_EN
  logic ovf_reg;
  logic err_reg;
  assign err = err_reg;
`else
  logic carry_unused;
  assign carry_unused = carry;
  assign err          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (load) begin
      state_next = en ? FETCH : IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (en) state_next = FETCH;
        FETCH:   state_next = CAPTURE;
        CAPTURE: state_next = HOLD;
        HOLD: begin
          if (instr_ready) begin
`ifdef PC_FETCH_BOUND_EN
            state_next = ovf_reg ? STOP : (en ? FETCH : IDLE);
`else
            state_next = en ? FETCH : IDLE;
`endif
          end
        end
`ifdef PC_FETCH_BOUND_EN
        STOP:    state_next = STOP;
`endif
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_rd = (state_reg == FETCH);
  end

  assign mem_addr    = pc;
  assign instr_valid = instr_valid_reg;
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_valid_reg <= 1'b0;
      instr_reg       <= '0;
      instr_pc_reg    <= '0;
`ifdef PC_FETCH_BOUND_EN
      ovf_reg         <= 1'b0;
      err_reg         <= 1'b0;
`endif
    end else if (load) begin
      instr_valid_reg <= 1'b0;
`ifdef PC_FETCH_BOUND_EN
      ovf_reg         <= 1'b0;
      err_reg         <= 1'b0;
`endif
    end else begin
      case (state_reg)
        CAPTURE: begin
          instr_reg       <= mem_rdata;
          instr_pc_reg    <= pc;
          instr_valid_reg <= 1'b1;
`ifdef PC_FETCH_BOUND_EN
          ovf_reg         <= carry;
`endif
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid_reg <= 1'b0;
`ifdef PC_FETCH_BOUND_EN
            // Overflowed word is delivered first; err rises on its handshake.
            err_reg         <= ovf_reg;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
